// File: rtl/soc_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one single-ported, fixed 1-cycle-latency TCDM slave among NR_MASTERS requesters.
// Optional per-master stall counters are enabled by defining SOC_TCDM_ARB_PERF_CNT_EN.
module soc_tcdm_rr_arbiter #(
    parameter int  NR_MASTERS = 4,
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 32,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int IDX_WIDTH  = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NR_MASTERS-1:0]            mst_req_i,
    input  logic [NR_MASTERS*ADDR_WIDTH-1:0] mst_add_i,
    input  logic [NR_MASTERS-1:0]            mst_wen_i,
    input  logic [NR_MASTERS*DATA_WIDTH-1:0] mst_wdata_i,
    input  logic [NR_MASTERS*BE_WIDTH-1:0]   mst_be_i,
    output logic [NR_MASTERS-1:0]            mst_gnt_o,
    output logic [NR_MASTERS-1:0]            mst_r_valid_o,
    output logic [DATA_WIDTH-1:0]            mst_r_rdata_o,
    output logic                             slv_req_o,
    output logic [ADDR_WIDTH-1:0]            slv_add_o,
    output logic                             slv_wen_o,
    output logic [DATA_WIDTH-1:0]            slv_wdata_o,
    output logic [BE_WIDTH-1:0]              slv_be_o,
    input  logic                             slv_gnt_i,
    input  logic                             slv_r_valid_i,
    input  logic [DATA_WIDTH-1:0]            slv_r_rdata_i,
    input  logic                             perf_clr_i,
    output logic [NR_MASTERS*32-1:0]         perf_stall_cnt_o
);

    logic [ADDR_WIDTH-1:0] add_arr   [NR_MASTERS];
    logic [DATA_WIDTH-1:0] wdata_arr [NR_MASTERS];
    logic [BE_WIDTH-1:0]   be_arr    [NR_MASTERS];

    logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  pend_q, pend_d;
    logic [IDX_WIDTH-1:0]  pend_idx_q, pend_idx_d;

    logic [IDX_WIDTH-1:0]  win_idx;
    logic [IDX_WIDTH:0]    cand;
    logic [IDX_WIDTH-1:0]  cand_idx;
    logic                  found;
    logic                  any_req;
    logic                  hs;

    genvar gi;
    for (gi = 0; gi < NR_MASTERS; gi++) begin : g_unpack
        assign add_arr[gi]   = mst_add_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = mst_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign be_arr[gi]    = mst_be_i[gi*BE_WIDTH +: BE_WIDTH];
    end

    // Scan from the round-robin pointer upward, wrapping modulo NR_MASTERS.
    always_comb begin
        win_idx  = '0;
        found    = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int k = 0; k < NR_MASTERS; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_WIDTH+1)'(k);
            if (cand >= (IDX_WIDTH+1)'(NR_MASTERS)) begin
                cand = cand - (IDX_WIDTH+1)'(NR_MASTERS);
            end
            cand_idx = cand[IDX_WIDTH-1:0];
            if (!found && mst_req_i[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    assign any_req   = |mst_req_i;
    assign slv_req_o = rst_ni & any_req;
    assign hs        = slv_req_o & slv_gnt_i;

    assign slv_add_o   = any_req ? add_arr[win_idx]   : '0;
    assign slv_wen_o   = any_req ? mst_wen_i[win_idx] : 1'b0;
    assign slv_wdata_o = any_req ? wdata_arr[win_idx] : '0;
    assign slv_be_o    = any_req ? be_arr[win_idx]    : '0;

    assign mst_gnt_o     = hs ? (NR_MASTERS'(1) << win_idx) : '0;
    assign mst_r_valid_o = (rst_ni & pend_q & slv_r_valid_i) ? (NR_MASTERS'(1) << pend_idx_q) : '0;
    assign mst_r_rdata_o = slv_r_rdata_i;

    // The pending slot is simply overwritten every cycle: the slave answers exactly one cycle later.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        pend_d     = 1'b0;
        pend_idx_d = pend_idx_q;
        if (hs) begin
            rr_ptr_d   = (win_idx == IDX_WIDTH'(NR_MASTERS-1)) ? '0 : win_idx + IDX_WIDTH'(1);
            pend_d     = 1'b1;
            pend_idx_d = win_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
        end
    end

`ifdef SOC_TCDM_ARB_PERF_CNT_EN
    for (gi = 0; gi < NR_MASTERS; gi++) begin : g_perf
        logic [31:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (perf_clr_i) begin
                cnt_d = '0;
            end else if (mst_req_i[gi] && !mst_gnt_o[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign perf_stall_cnt_o[gi*32 +: 32] = cnt_q;
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr  = perf_clr_i;
    assign perf_stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    // A response with nothing outstanding has no owner and is dropped.
    spurious_r_valid: assert property (@(posedge clk_i) disable iff (!rst_ni) slv_r_valid_i |-> pend_q)
        else $warning("soc_tcdm_rr_arbiter: slv_r_valid_i with no outstanding request, response dropped");
`endif

endmodule

// File: tb/tb_soc_tcdm_rr_arbiter.sv
// Self-checking bench for soc_tcdm_rr_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model of the round-robin policy.
module tb_soc_tcdm_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [N-1:0]      mst_req_i;
    logic [N*AW-1:0]   mst_add_i;
    logic [N-1:0]      mst_wen_i;
    logic [N*DW-1:0]   mst_wdata_i;
    logic [N*BW-1:0]   mst_be_i;
    logic [N-1:0]      mst_gnt_o;
    logic [N-1:0]      mst_r_valid_o;
    logic [DW-1:0]     mst_r_rdata_o;
    logic              slv_req_o;
    logic [AW-1:0]     slv_add_o;
    logic              slv_wen_o;
    logic [DW-1:0]     slv_wdata_o;
    logic [BW-1:0]     slv_be_o;
    logic              slv_gnt_i;
    logic              slv_r_valid_i;
    logic [DW-1:0]     slv_r_rdata_i;
    logic              perf_clr_i;
    logic [N*32-1:0]   perf_stall_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_ptr;
    bit          m_pend;
    int          m_idx;
    logic [31:0] m_cnt [N];

    always #5 clk_i = ~clk_i;

    soc_tcdm_rr_arbiter #(.NR_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mst_req_i(mst_req_i), .mst_add_i(mst_add_i), .mst_wen_i(mst_wen_i),
        .mst_wdata_i(mst_wdata_i), .mst_be_i(mst_be_i),
        .mst_gnt_o(mst_gnt_o), .mst_r_valid_o(mst_r_valid_o), .mst_r_rdata_o(mst_r_rdata_o),
        .slv_req_o(slv_req_o), .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o),
        .slv_wdata_o(slv_wdata_o), .slv_be_o(slv_be_o),
        .slv_gnt_i(slv_gnt_i), .slv_r_valid_i(slv_r_valid_i), .slv_r_rdata_i(slv_r_rdata_i),
        .perf_clr_i(perf_clr_i), .perf_stall_cnt_o(perf_stall_cnt_o)
    );

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (mst_req_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        int w;
        w = model_winner();
        if (rst_ni && slv_gnt_i && w >= 0) return N'(1) << w;
        return '0;
    endfunction

    function automatic logic [N-1:0] exp_rvalid();
        if (rst_ni && m_pend && slv_r_valid_i) return N'(1) << m_idx;
        return '0;
    endfunction

    function automatic logic [AW-1:0] exp_add();
        int w;
        w = model_winner();
        if (w < 0) return '0;
        return mst_add_i[w*AW +: AW];
    endfunction

    function automatic logic [N*32-1:0] exp_perf();
        logic [N*32-1:0] p;
        p = '0;
`ifdef SOC_TCDM_ARB_PERF_CNT_EN
        for (int i = 0; i < N; i++) p[i*32 +: 32] = m_cnt[i];
`endif
        return p;
    endfunction

    // Advance one clock and apply the arbitration rules to the model.
    task automatic tick();
        int w;
        logic [N-1:0] g;
        w = model_winner();
        g = exp_gnt();
        @(posedge clk_i);
        if (!rst_ni) begin
            m_ptr = 0; m_pend = 0; m_idx = 0;
        end else if (g != '0) begin
            m_ptr = (w + 1) % N; m_pend = 1; m_idx = w;
        end else begin
            m_pend = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (!rst_ni || perf_clr_i) m_cnt[i] = '0;
            else if (mst_req_i[i] && !g[i] && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
        end
        #1;
    endtask

    task automatic randomize_payload();
        for (int i = 0; i < N; i++) begin
            mst_add_i[i*AW +: AW]   = $urandom;
            mst_wdata_i[i*DW +: DW] = $urandom;
            mst_be_i[i*BW +: BW]    = BW'($urandom_range(0, 15));
        end
        mst_wen_i = N'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; mst_req_i = '1; slv_gnt_i = 1'b1; slv_r_valid_i = 1'b1; perf_clr_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #3;
            n_vec++; if (slv_req_o !== 1'b0) begin n_err++; $display("FAIL reset_slv_req cyc=%0d got=%b exp=0", c, slv_req_o); end
            n_vec++; if (mst_gnt_o !== '0) begin n_err++; $display("FAIL reset_gnt cyc=%0d got=%b exp=0", c, mst_gnt_o); end
            n_vec++; if (mst_r_valid_o !== '0) begin n_err++; $display("FAIL reset_rvalid cyc=%0d got=%b exp=0", c, mst_r_valid_o); end
            tick();
        end
        rst_ni = 1'b1; mst_req_i = '0; slv_r_valid_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #3;
            n_vec++; if (slv_req_o !== 1'b0) begin n_err++; $display("FAIL idle_slv_req cyc=%0d got=%b exp=0", c, slv_req_o); end
            n_vec++; if (mst_gnt_o !== '0) begin n_err++; $display("FAIL idle_gnt cyc=%0d got=%b exp=0", c, mst_gnt_o); end
            n_vec++; if (mst_r_valid_o !== '0) begin n_err++; $display("FAIL idle_rvalid cyc=%0d got=%b exp=0", c, mst_r_valid_o); end
            n_vec++; if (slv_add_o !== '0) begin n_err++; $display("FAIL idle_slv_add cyc=%0d got=%h exp=0", c, slv_add_o); end
            tick();
        end
        n_vec++; if (perf_stall_cnt_o !== '0) begin n_err++; $display("FAIL reset_perf got=%h exp=0", perf_stall_cnt_o); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        mst_req_i = '1; slv_gnt_i = 1'b1;
        for (int c = 0; c < 9; c++) begin
            randomize_payload();
            slv_r_valid_i = m_pend;
            slv_r_rdata_i = 32'hA5A5_0000 + 32'(m_idx);
            #3;
            eg = N'(1) << (c % N);
            n_vec++; if (mst_gnt_o !== eg) begin n_err++; $display("FAIL rr_order cyc=%0d got=%b exp=%b", c, mst_gnt_o, eg); end
            n_vec++; if (slv_add_o !== mst_add_i[(c % N)*AW +: AW]) begin n_err++; $display("FAIL rr_add cyc=%0d got=%h exp=%h", c, slv_add_o, mst_add_i[(c % N)*AW +: AW]); end
            n_vec++; if (slv_wdata_o !== mst_wdata_i[(c % N)*DW +: DW]) begin n_err++; $display("FAIL rr_wdata cyc=%0d got=%h exp=%h", c, slv_wdata_o, mst_wdata_i[(c % N)*DW +: DW]); end
            if (c > 0) begin
                eg = N'(1) << ((c - 1) % N);
                n_vec++; if (mst_r_valid_o !== eg) begin n_err++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=%b", c, mst_r_valid_o, eg); end
                n_vec++; if (mst_r_rdata_o !== 32'hA5A5_0000 + 32'((c - 1) % N)) begin n_err++; $display("FAIL rr_rdata cyc=%0d got=%h exp=%h", c, mst_r_rdata_o, 32'hA5A5_0000 + 32'((c - 1) % N)); end
            end
            tick();
        end
        slv_r_valid_i = 1'b0;
    endtask

    task automatic test_wrap();
        logic [N-1:0] seq [3];
        seq[0] = 4'b1000; seq[1] = 4'b0010; seq[2] = 4'b1000;
        // Pointer is at 1 after the round-robin run; one grant to master 1 moves it to 2.
        mst_req_i = 4'b0010; slv_gnt_i = 1'b1; slv_r_valid_i = m_pend;
        #3;
        n_vec++; if (mst_gnt_o !== 4'b0010) begin n_err++; $display("FAIL wrap_setup got=%b exp=0010", mst_gnt_o); end
        tick();
        mst_req_i = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            slv_r_valid_i = m_pend;
            #3;
            n_vec++; if (mst_gnt_o !== seq[c]) begin n_err++; $display("FAIL wrap_order cyc=%0d got=%b exp=%b", c, mst_gnt_o, seq[c]); end
            n_vec++; if (mst_gnt_o !== exp_gnt()) begin n_err++; $display("FAIL wrap_model cyc=%0d got=%b exp=%b", c, mst_gnt_o, exp_gnt()); end
            tick();
        end
        slv_r_valid_i = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] lit;
        mst_req_i = '0; perf_clr_i = 1'b1; slv_r_valid_i = 1'b0;
        tick();
        perf_clr_i = 1'b0; mst_req_i = 4'b0100; slv_gnt_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #3;
            n_vec++; if (mst_gnt_o !== '0) begin n_err++; $display("FAIL stall_gnt cyc=%0d got=%b exp=0", c, mst_gnt_o); end
            n_vec++; if (slv_req_o !== 1'b1) begin n_err++; $display("FAIL stall_slv_req cyc=%0d got=%b exp=1", c, slv_req_o); end
            n_vec++; if (slv_add_o !== mst_add_i[2*AW +: AW]) begin n_err++; $display("FAIL stall_add cyc=%0d got=%h exp=%h", c, slv_add_o, mst_add_i[2*AW +: AW]); end
            tick();
        end
        mst_req_i = '0;
        #3;
`ifdef SOC_TCDM_ARB_PERF_CNT_EN
        lit = 32'd5;
`else
        lit = 32'd0;
`endif
        n_vec++; if (perf_stall_cnt_o[2*32 +: 32] !== lit) begin n_err++; $display("FAIL stall_cnt2 got=%0d exp=%0d", perf_stall_cnt_o[2*32 +: 32], lit); end
        n_vec++; if (perf_stall_cnt_o !== exp_perf()) begin n_err++; $display("FAIL stall_cnt_all got=%h exp=%h", perf_stall_cnt_o, exp_perf()); end
        perf_clr_i = 1'b1;
        tick();
        perf_clr_i = 1'b0;
        #3;
        n_vec++; if (perf_stall_cnt_o !== '0) begin n_err++; $display("FAIL stall_clr got=%h exp=0", perf_stall_cnt_o); end
        // Pointer must not have moved: all request, winner follows the model pointer.
        mst_req_i = '1; slv_gnt_i = 1'b1;
        #1;
        n_vec++; if (mst_gnt_o !== exp_gnt()) begin n_err++; $display("FAIL stall_ptr_hold got=%b exp=%b", mst_gnt_o, exp_gnt()); end
        tick();
        mst_req_i = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        mst_req_i = 4'b0010; slv_gnt_i = 1'b1; slv_r_valid_i = 1'b0;
        #3;
        n_vec++; if (mst_gnt_o !== 4'b0010) begin n_err++; $display("FAIL rmid_hs got=%b exp=0010", mst_gnt_o); end
        tick();
        rst_ni = 1'b0; mst_req_i = '0; slv_r_valid_i = 1'b1; slv_r_rdata_i = 32'hDEAD_BEEF;
        #3;
        n_vec++; if (mst_r_valid_o !== '0) begin n_err++; $display("FAIL rmid_rvalid got=%b exp=0", mst_r_valid_o); end
        tick();
        rst_ni = 1'b1; slv_r_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_spurious();
        mst_req_i = '0; slv_gnt_i = 1'b1; slv_r_valid_i = 1'b1; slv_r_rdata_i = 32'h1234_5678;
        #3;
        n_vec++; if (mst_r_valid_o !== '0) begin n_err++; $display("FAIL spurious_rvalid got=%b exp=0", mst_r_valid_o); end
        n_vec++; if (mst_r_rdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL spurious_rdata got=%h exp=12345678", mst_r_rdata_o); end
        tick();
        slv_r_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int w;
        for (int c = 0; c < 400; c++) begin
            rst_ni        = ($urandom_range(0, 63) != 0);
            mst_req_i     = N'($urandom_range(0, 15));
            slv_gnt_i     = ($urandom_range(0, 3) != 0);
            slv_r_valid_i = m_pend;
            slv_r_rdata_i = $urandom;
            perf_clr_i    = ($urandom_range(0, 31) == 0);
            randomize_payload();
            #3;
            w = model_winner();
            n_vec++; if (mst_gnt_o !== exp_gnt()) begin n_err++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, mst_gnt_o, exp_gnt()); end
            n_vec++; if (slv_req_o !== (rst_ni && mst_req_i != '0)) begin n_err++; $display("FAIL rnd_slv_req cyc=%0d got=%b exp=%b", c, slv_req_o, (rst_ni && mst_req_i != '0)); end
            n_vec++; if (mst_r_valid_o !== exp_rvalid()) begin n_err++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, mst_r_valid_o, exp_rvalid()); end
            n_vec++; if (perf_stall_cnt_o !== exp_perf()) begin n_err++; $display("FAIL rnd_perf cyc=%0d got=%h exp=%h", c, perf_stall_cnt_o, exp_perf()); end
            if (rst_ni) begin
                n_vec++; if (slv_add_o !== exp_add()) begin n_err++; $display("FAIL rnd_add cyc=%0d got=%h exp=%h", c, slv_add_o, exp_add()); end
                if (w >= 0) begin
                    n_vec++; if ({slv_wen_o, slv_be_o, slv_wdata_o} !== {mst_wen_i[w], mst_be_i[w*BW +: BW], mst_wdata_i[w*DW +: DW]}) begin
                        n_err++; $display("FAIL rnd_payload cyc=%0d got=%b/%h/%h exp=%b/%h/%h", c, slv_wen_o, slv_be_o, slv_wdata_o, mst_wen_i[w], mst_be_i[w*BW +: BW], mst_wdata_i[w*DW +: DW]);
                    end
                end
            end
            tick();
        end
        rst_ni = 1'b1; mst_req_i = '0; slv_r_valid_i = 1'b0; perf_clr_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_ni = 1'b0; mst_req_i = '0; mst_add_i = '0; mst_wen_i = '0; mst_wdata_i = '0; mst_be_i = '0;
        slv_gnt_i = 1'b0; slv_r_valid_i = 1'b0; slv_r_rdata_i = '0; perf_clr_i = 1'b0;
        m_ptr = 0; m_pend = 0; m_idx = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = '0;
        @(posedge clk_i); #1;
        test_reset();
        test_round_robin();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/soc_tcdm_rr_arbiter.md
Name: soc_tcdm_rr_arbiter

Overview:
Round-robin arbiter that shares one single-ported TCDM slave among NR_MASTERS TCDM requesters. Typical slaves are a core-private L2 bank or the boot ROM. It sits between the SoC interconnect's contiguous-region ports and the memory macro. It multiplexes request/address/data, tracks which master owns each outstanding response, and routes the 1-cycle-latency response back to that master.

Parameters:
- NR_MASTERS, 4, number of requesting TCDM ports (≥1).
- ADDR_WIDTH, 32, address width (SoC-wide 32-bit).
- DATA_WIDTH, 32, data width; BE_WIDTH = DATA_WIDTH/8 (derived localparam).
- IDX_WIDTH, derived localparam = max(1, $clog2(NR_MASTERS)).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- mst_req_i  in  NR_MASTERS  request per master.
- mst_add_i  in  NR_MASTERS*ADDR_WIDTH  address per master.
- mst_wen_i  in  NR_MASTERS  1=read, 0=write.
- mst_wdata_i  in  NR_MASTERS*DATA_WIDTH  write data.
- mst_be_i  in  NR_MASTERS*BE_WIDTH  byte enables.
- mst_gnt_o  out  NR_MASTERS  grant, one-hot or zero.
- mst_r_valid_o  out  NR_MASTERS  response valid, one-hot or zero.
- mst_r_rdata_o  out  DATA_WIDTH  read data, broadcast to all masters.
- slv_req_o  out  1  request to slave.
- slv_add_o  out  ADDR_WIDTH  selected address.
- slv_wen_o  out  1  selected wen.
- slv_wdata_o  out  DATA_WIDTH  selected wdata.
- slv_be_o  out  BE_WIDTH  selected byte enables.
- slv_gnt_i  in  1  slave grant.
- slv_r_valid_i  in  1  slave response valid, exactly 1 cycle after the handshake.
- slv_r_rdata_i  in  DATA_WIDTH  slave read data.
- perf_clr_i  in  1  clear performance counters (used only with the optional feature).
- perf_stall_cnt_o  out  NR_MASTERS*32  per-master stall counters (used only with the optional feature).

Behaviour:
- Single clock clk_i; reset rst_ni is synchronous and active-low. All state is updated on the rising edge of clk_i.
- While rst_ni=0:
  - slv_req_o=0, mst_gnt_o=0, mst_r_valid_o=0.
  - rr_ptr_q<=0, pend_q<=0, pend_idx_q<=0.
- Arbitration is combinational and zero-latency:
  - Winner w = first i with mst_req_i[i]=1, searching from rr_ptr_q upward with wrap-around modulo NR_MASTERS.
  - slv_req_o = |mst_req_i.
  - slv_add_o, slv_wen_o, slv_wdata_o and slv_be_o come from master w. When there is no request they drive 0.
  - mst_gnt_o[w] = slv_gnt_i & slv_req_o; all other grant bits are 0.
- Handshake: hs = slv_req_o & slv_gnt_i. On hs:
  - rr_ptr_q <= (w+1) mod NR_MASTERS. If w = NR_MASTERS-1, the pointer wraps to 0.
  - pend_q <= 1 and pend_idx_q <= w.
- Without hs, rr_ptr_q holds. pend_q <= 0 when there is no hs in that cycle.
- Response routing:
  - mst_r_valid_o[pend_idx_q] = slv_r_valid_i & pend_q; all other bits are 0.
  - mst_r_rdata_o = slv_r_rdata_i, passed through unregistered.
- Back-to-back handshakes every cycle are supported. The pending register is overwritten each cycle, which is valid because slave latency is fixed at 1.
- Fairness: a continuously requesting master is granted within NR_MASTERS handshakes.
- Masters may drop or change a request that has not been granted. Arbitration re-evaluates every cycle and holds no lock.
- Writes also produce a response (r_valid) and are routed identically to reads.
- slv_r_valid_i while pend_q=0 is dropped: no mst_r_valid_o is raised. A simulation-only assertion flags it.
- If reset is asserted mid-transaction, the outstanding response is discarded: pend_q is cleared and the next-cycle r_valid is not forwarded.
- NR_MASTERS=1: the block is a pure passthrough plus the pending register; rr_ptr_q is constant 0.

Optional Feature:
Macro: SOC_TCDM_ARB_PERF_CNT_EN
- Defined:
  - One 32-bit saturating counter per master, incremented each cycle with mst_req_i[i]=1 & mst_gnt_o[i]=0.
  - Each counter saturates at 0xFFFFFFFF.
  - perf_clr_i=1 zeroes all counters next cycle and takes priority over increment.
  - Counters reset to 0.
- Undefined: perf_stall_cnt_o is tied to 0, perf_clr_i is ignored, and no counter flops are synthesized. Port list is identical in both builds.

Test Plan:
- Reset then idle (all mst_req_i=0) -> slv_req_o=0, mst_gnt_o=0, mst_r_valid_o=0 for 10 cycles.
- NR_MASTERS=4, all four requesting continuously, slv_gnt_i=1 -> grants 0,1,2,3,0,... each cycle. mst_r_valid_o one cycle after each grant equals the granted one-hot. rdata 0xA5A5_0000+idx reaches the correct master.
- Masters 1 and 3 request, rr_ptr_q=2, slv_gnt_i=1 -> master 3 granted first, then master 1; pointer wraps 3->0.
- slv_gnt_i=0 for 5 cycles with master 2 requesting -> no grant and rr_ptr_q unchanged. With the macro defined, perf_stall_cnt_o[2]=5; perf_clr_i pulse -> 0 next cycle.
- Handshake on master 1, rst_ni=0 in the following cycle with slv_r_valid_i=1 -> mst_r_valid_o=0, pend_q=0 after reset.
- Spurious slv_r_valid_i=1 with no prior handshake -> all mst_r_valid_o=0 and the assertion fires.
